csr_timer_unit: RTL and testbench
=================================

// Module: csr_timer_unit
// PURPOSE
//  Responder side of the pipeline CSR access (CsrCtrl fields) for the timer CSRs TID/TCFG/TVAL/TICLR.
//  Owns the constant-frequency countdown timer and drives the timer-interrupt pending bit (ESTAT.IS[11]).
//  Sits beside the main CSR file; the WB stage issues commit-time CSR requests to both.
// PARAMETERS
//  TIMESIZE   7        width of TVAL and of TCFG.InitVal (TCFG[TIMESIZE+1:2])
//  TID_RESET  32'h0    reset value of TID
//  PRESCALE   4        decrement period in cycles (only with CSR_TIMER_PRESCALE_EN; >=1)
// PORTS
//  aclk           in   1   clock
//  reset          in   1   synchronous, active-high reset
//  csr_ren        in   1   read request, sampled every cycle
//  csr_wen        in   1   write request (csrwr/csrxchg), commit-time only
//  is_musk        in   1   1 = csrxchg masked write
//  musk           in   32  write mask when is_musk
//  csrnum         in   14  CSR address (CsrAddr)
//  csr_writedata  in   32  write data
//  csr_hit        out  1   comb: csrnum is TID/TCFG/TVAL/TICLR
//  csr_rvalid     out  1   registered: read data valid
//  csr_rdata      out  32  registered read data
//  timer_int      out  1   TI pending -> ESTAT.IS[11]
// BEHAVIOUR
//  Reset: TCFG=0, TVAL=0, TI=0, TID=TID_RESET, csr_rvalid=0, csr_rdata=0, prescaler=0.
//  Read: csr_ren&hit in cycle N -> csr_rvalid=1, csr_rdata in N+1; value is pre-write state of N.
//   TVAL zero-extended; TICLR reads 0; TCFG bits above TIMESIZE+1 read 0. ren&~hit -> rvalid=0.
//  Write: wv = is_musk ? (old&~musk)|(csr_writedata&musk) : csr_writedata; TCFG stores wv&TCFG_WM,
//   TID stores wv; TVAL writes ignored; TICLR: wv[0]=1 clears TI, nothing stored. Effect at end of N.
//  TCFG write with En=1: TVAL<=wv[TIMESIZE+1:2]; En=0: TVAL holds. Prescaler cleared on any TCFG write.
//  Count (En=1, TVAL!=0, tick): TVAL-1; on TVAL==1 tick: TI<=1, TVAL<=Periodic?InitVal:0.
//   One-shot then holds 0, no further TI. InitVal=0: no counting, no TI in either mode.
//   Timing: TCFG written in N -> TVAL=InitVal in N+1, InitVal-1 in N+2, TI visible N+InitVal+1.
//   Periodic period = InitVal cycles (TVAL sequence InitVal..1).
//  Collisions: expiry & TICLR clear same cycle -> TI=1 (set wins). Expiry & TCFG write same cycle ->
//   TVAL/TCFG take write value, TI still sets. En=0 -> TVAL frozen, TI unaffected.
//  Reset mid-count: all state to reset values next cycle; no pending TI survives.
// CONFIGURATION
//  CSR_TIMER_PRESCALE_EN defined: tick asserted once every PRESCALE cycles (prescaler wraps
//   PRESCALE-1 -> 0, tick on wrap); timing above scales by PRESCALE. Undefined: tick=1 every cycle,
//   PRESCALE ignored, no prescaler flops.
// STRUCTURE
//  cpuDefine package: reuse TID/TCFG/TVAL/TICLR addresses, TIMESIZE, TCFG_WM, TCFG_RM/TVAL_RM;
//   add localparam TI_BIT=11 and TICLR_CLR_BIT=0 there.
//  One sub-module: timer_prescaler (counter + tick), instantiated only under CSR_TIMER_PRESCALE_EN.
// TESTING (TIMESIZE=7, macro off)
//  1 write TCFG=0x15 (InitVal 5, one-shot) -> TVAL 5,4,3,2,1,0 then hold 0; TI=1 once, stays until clear.
//  2 write TCFG=0x17 (periodic) -> TVAL 5,4,3,2,1,5..; TICLR=1 after each expiry -> TI pulses every 5 cycles.
//  3 TICLR=1 same cycle as expiry -> TI remains 1; TICLR read -> csr_rdata=0, rvalid next cycle.
//  4 csrxchg TCFG(0x17) musk=0x1 wdata=0 -> TCFG=0x16, TVAL frozen; TVAL write 0x7F ignored.
//  5 write TCFG=0xFFFFFFFF -> reads 0x1FF; TID write 0xDEADBEEF reads back; reset mid-count -> TVAL=0, TI=0.
//  6 macro on, PRESCALE=4, TCFG=0x09 (InitVal 2) -> TVAL steps every 4 cycles; TI after 8 cycles.

Source files
------------

// File: rtl/csr_timer_unit_pkg.sv
// Shared CSR addresses, timer geometry and field masks for the timer CSR responder.
package csr_timer_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 14;

    localparam logic [CSR_ADDR_W-1:0] CSR_TID   = 14'h040;
    localparam logic [CSR_ADDR_W-1:0] CSR_TCFG  = 14'h041;
    localparam logic [CSR_ADDR_W-1:0] CSR_TVAL  = 14'h042;
    localparam logic [CSR_ADDR_W-1:0] CSR_TICLR = 14'h044;

    localparam int unsigned TIMESIZE          = 7;
    localparam int unsigned TCFG_EN_BIT       = 0;
    localparam int unsigned TCFG_PERIODIC_BIT = 1;
    localparam int unsigned TI_BIT            = 11;
    localparam int unsigned TICLR_CLR_BIT     = 0;

    // All-ones in the low n bits of an XLEN word.
    function automatic logic [XLEN-1:0] low_mask(input int unsigned n);
        logic [XLEN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [XLEN-1:0] TCFG_WM = low_mask(TIMESIZE + 2);
    localparam logic [XLEN-1:0] TCFG_RM = TCFG_WM;
    localparam logic [XLEN-1:0] TVAL_RM = low_mask(TIMESIZE);

endpackage

// File: rtl/csr_timer_unit_timer_prescaler.sv
// Free-running divide-by-PRESCALE counter; tick_o marks the wrap cycle.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned    CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_MAX);

    // Count up, wrap after the tick, restart on a timer reconfiguration.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/csr_timer_unit.sv
// Timer CSR responder (TID/TCFG/TVAL/TICLR): countdown timer and TI pending bit.
// Optional feature macro: CSR_TIMER_PRESCALE_EN (decrement once every PRESCALE cycles).
module csr_timer_unit
    import csr_timer_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] TID_RESET = 32'h0,
    parameter int unsigned     PRESCALE  = 4
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  csr_ren,
    input  logic                  csr_wen,
    input  logic                  is_musk,
    input  logic [XLEN-1:0]       musk,
    input  logic [CSR_ADDR_W-1:0] csrnum,
    input  logic [XLEN-1:0]       csr_writedata,
    output logic                  csr_hit,
    output logic                  csr_rvalid,
    output logic [XLEN-1:0]       csr_rdata,
    output logic                  timer_int
);

    localparam int unsigned TW = TIMESIZE;
    localparam int unsigned CW = TIMESIZE + 2;

    logic            sel_tid, sel_tcfg, sel_tval, sel_ticlr;
    logic [XLEN-1:0] cur_val, wv;
    logic            tcfg_wr, tid_wr, ticlr_wr, tick, expire;

    logic [XLEN-1:0] tid_q, tid_d;
    logic [CW-1:0]   tcfg_q, tcfg_d;
    logic [TW-1:0]   tval_q, tval_d;
    logic            ti_q, ti_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    if (PRESCALE < 1) begin : g_prescale_chk
        $error("csr_timer_unit: PRESCALE must be at least 1");
    end

`ifdef CSR_TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (aclk),
        .rst_i  (reset),
        .clr_i  (tcfg_wr),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Address decode, current register value and merged (csrxchg) write value.
    always_comb begin
        sel_tid   = (csrnum == CSR_TID);
        sel_tcfg  = (csrnum == CSR_TCFG);
        sel_tval  = (csrnum == CSR_TVAL);
        sel_ticlr = (csrnum == CSR_TICLR);
        csr_hit   = sel_tid | sel_tcfg | sel_tval | sel_ticlr;

        cur_val = '0;
        if (sel_tid)  cur_val = tid_q;
        if (sel_tcfg) cur_val = XLEN'(tcfg_q) & TCFG_RM;
        if (sel_tval) cur_val = XLEN'(tval_q) & TVAL_RM;

        wv = is_musk ? ((cur_val & ~musk) | (csr_writedata & musk)) : csr_writedata;

        tid_wr   = csr_wen & sel_tid;
        tcfg_wr  = csr_wen & sel_tcfg;
        ticlr_wr = csr_wen & sel_ticlr;
    end

    // Next state: config writes, countdown/reload, TI set-over-clear, read capture.
    always_comb begin
        tid_d    = tid_wr  ? wv : tid_q;
        tcfg_d   = tcfg_wr ? CW'(wv & TCFG_WM) : tcfg_q;
        tval_d   = tval_q;
        ti_d     = ti_q;
        expire   = 1'b0;
        rvalid_d = csr_ren & csr_hit;
        rdata_d  = (csr_ren & csr_hit) ? cur_val : rdata_q;

        if (tcfg_q[TCFG_EN_BIT] && (tval_q != '0) && tick) begin
            if (tval_q == TW'(1)) begin
                expire = 1'b1;
                tval_d = tcfg_q[TCFG_PERIODIC_BIT] ? tcfg_q[CW-1:2] : '0;
            end else begin
                tval_d = tval_q - TW'(1);
            end
        end

        // A TCFG write overrides the countdown; with En=0 TVAL keeps its old value.
        if (tcfg_wr) tval_d = wv[TCFG_EN_BIT] ? wv[CW-1:2] : tval_q;

        if (ticlr_wr && wv[TICLR_CLR_BIT]) ti_d = 1'b0;
        if (expire)                        ti_d = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (reset) begin
            tid_q    <= TID_RESET;
            tcfg_q   <= '0;
            tval_q   <= '0;
            ti_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
            ti_q     <= ti_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign csr_rvalid = rvalid_q;
    assign csr_rdata  = rdata_q;
    assign timer_int  = ti_q;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Directed bench for csr_timer_unit; read data checked through an expected-value queue.
module tb_csr_timer_unit;
    import csr_timer_unit_pkg::*;

    localparam logic [31:0] TB_TID_RESET = 32'hA5A5_0001;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_ren = 1'b0;
    logic        csr_wen = 1'b0;
    logic        is_musk = 1'b0;
    logic [31:0] musk = '0;
    logic [13:0] csrnum = '0;
    logic [31:0] csr_writedata = '0;
    logic        csr_hit;
    logic        csr_rvalid;
    logic [31:0] csr_rdata;
    logic        timer_int;
    logic [12:0] estat_is;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] mon_exp;
    string       mon_tag;

    csr_timer_unit #(
        .TID_RESET (TB_TID_RESET),
        .PRESCALE  (4)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .csr_ren       (csr_ren),
        .csr_wen       (csr_wen),
        .is_musk       (is_musk),
        .musk          (musk),
        .csrnum        (csrnum),
        .csr_writedata (csr_writedata),
        .csr_hit       (csr_hit),
        .csr_rvalid    (csr_rvalid),
        .csr_rdata     (csr_rdata),
        .timer_int     (timer_int)
    );

    always #5 aclk = ~aclk;

    assign estat_is = 13'(timer_int) << TI_BIT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ti(input string tag, input logic exp_ti);
        check({tag, "_ti"}, 32'(estat_is), 32'(13'(exp_ti) << TI_BIT));
    endtask

    task automatic idle(input logic exp_ti);
        @(negedge aclk);
        reset = 1'b0; csr_ren = 1'b0; csr_wen = 1'b0; is_musk = 1'b0;
        #1 check_ti("idle", exp_ti);
    endtask

    task automatic do_reset(input logic exp_ti);
        @(negedge aclk);
        reset = 1'b1; csr_ren = 1'b0; csr_wen = 1'b0; is_musk = 1'b0;
        #1 check_ti("rst", exp_ti);
    endtask

    task automatic rd(input string tag, input logic [13:0] addr, input logic exp_hit,
                      input logic [31:0] exp_data, input logic exp_ti);
        @(negedge aclk);
        reset = 1'b0; csr_ren = 1'b1; csr_wen = 1'b0; is_musk = 1'b0; csrnum = addr;
        if (exp_hit) begin
            exp_q.push_back(exp_data);
            tag_q.push_back(tag);
        end
        #1;
        check({tag, "_hit"}, 32'(csr_hit), 32'(exp_hit));
        check_ti(tag, exp_ti);
    endtask

    task automatic wr(input string tag, input logic [13:0] addr, input logic [31:0] data,
                      input logic m_en, input logic [31:0] m, input logic exp_ti);
        @(negedge aclk);
        reset = 1'b0; csr_ren = 1'b0; csr_wen = 1'b1; csrnum = addr;
        csr_writedata = data; is_musk = m_en; musk = m;
        #1 check_ti(tag, exp_ti);
    endtask

    // Read responses: every rvalid must match the oldest outstanding read.
    always @(negedge aclk) begin
        if (csr_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL rvalid_spurious: observed rvalid 1 expected 0");
                end
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, csr_rdata, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge aclk);
        idle(1'b0);
        check("rst_rvalid", 32'(csr_rvalid), 32'h0);
        check("rst_rdata", csr_rdata, 32'h0);
        rd("rst_tcfg", CSR_TCFG, 1'b1, 32'h0, 1'b0);
        rd("rst_tval", CSR_TVAL, 1'b1, 32'h0, 1'b0);
        rd("rst_tid", CSR_TID, 1'b1, TB_TID_RESET, 1'b0);
        rd("miss", 14'h000, 1'b0, 32'h0, 1'b0);
        idle(1'b0);

`ifdef CSR_TIMER_PRESCALE_EN
        wr("pre_tcfg", CSR_TCFG, 32'h09, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) rd("pre_tval2", CSR_TVAL, 1'b1, 32'd2, 1'b0);
        for (int i = 0; i < 4; i++) rd("pre_tval1", CSR_TVAL, 1'b1, 32'd1, 1'b0);
        rd("pre_tval0", CSR_TVAL, 1'b1, 32'd0, 1'b1);
        rd("pre_hold", CSR_TVAL, 1'b1, 32'd0, 1'b1);
`else
        // One-shot InitVal 5.
        wr("os_tcfg", CSR_TCFG, 32'h15, 1'b0, 32'h0, 1'b0);
        for (int i = 5; i >= 1; i--) rd("os_tval", CSR_TVAL, 1'b1, 32'(i), 1'b0);
        rd("os_zero", CSR_TVAL, 1'b1, 32'd0, 1'b1);
        rd("os_hold", CSR_TVAL, 1'b1, 32'd0, 1'b1);
        idle(1'b1);
        wr("os_clr0", CSR_TICLR, 32'h0, 1'b0, 32'h0, 1'b1);
        wr("os_clr1", CSR_TICLR, 32'h1, 1'b0, 32'h0, 1'b1);
        rd("os_after", CSR_TVAL, 1'b1, 32'd0, 1'b0);

        // Periodic InitVal 5, clear after each expiry, then clear on the expiry cycle.
        wr("per_tcfg", CSR_TCFG, 32'h17, 1'b0, 32'h0, 1'b0);
        for (int i = 5; i >= 1; i--) rd("per_tval_a", CSR_TVAL, 1'b1, 32'(i), 1'b0);
        wr("per_clr_a", CSR_TICLR, 32'h1, 1'b0, 32'h0, 1'b1);
        for (int i = 4; i >= 1; i--) rd("per_tval_b", CSR_TVAL, 1'b1, 32'(i), 1'b0);
        wr("per_clr_b", CSR_TICLR, 32'h1, 1'b0, 32'h0, 1'b1);
        for (int i = 4; i >= 2; i--) rd("per_tval_c", CSR_TVAL, 1'b1, 32'(i), 1'b0);
        wr("coll_clr", CSR_TICLR, 32'h1, 1'b0, 32'h0, 1'b0);
        rd("coll_reload", CSR_TVAL, 1'b1, 32'd5, 1'b1);
        rd("ticlr_rd", CSR_TICLR, 1'b1, 32'h0, 1'b1);

        // csrxchg clearing En freezes TVAL; TVAL writes are ignored.
        wr("xchg_tcfg", CSR_TCFG, 32'h0, 1'b1, 32'h1, 1'b1);
        rd("xchg_rd", CSR_TCFG, 1'b1, 32'h16, 1'b1);
        wr("tval_wr", CSR_TVAL, 32'h7F, 1'b0, 32'h0, 1'b1);
        rd("frozen", CSR_TVAL, 1'b1, 32'd3, 1'b1);
        wr("frz_clr", CSR_TICLR, 32'h1, 1'b0, 32'h0, 1'b1);
        rd("frozen2", CSR_TVAL, 1'b1, 32'd3, 1'b0);

        // Periodic with InitVal 0 never counts or fires.
        wr("iv0_tcfg", CSR_TCFG, 32'h03, 1'b0, 32'h0, 1'b0);
        rd("iv0_a", CSR_TVAL, 1'b1, 32'd0, 1'b0);
        rd("iv0_b", CSR_TVAL, 1'b1, 32'd0, 1'b0);
        idle(1'b0);

        // Field masking and TID.
        wr("all1_tcfg", CSR_TCFG, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        rd("all1_rd", CSR_TCFG, 1'b1, 32'h1FF, 1'b0);
        rd("all1_tval", CSR_TVAL, 1'b1, 32'h7E, 1'b0);
        wr("tid_wr", CSR_TID, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        rd("tid_rd", CSR_TID, 1'b1, 32'hDEAD_BEEF, 1'b0);
        wr("tid_xchg", CSR_TID, 32'h1234_0000, 1'b1, 32'hFFFF_0000, 1'b0);
        rd("tid_xrd", CSR_TID, 1'b1, 32'h1234_BEEF, 1'b0);

        // Expiry coinciding with a TCFG write, then reset mid-count.
        wr("cw_tcfg", CSR_TCFG, 32'h09, 1'b0, 32'h0, 1'b0);
        rd("cw_tval2", CSR_TVAL, 1'b1, 32'd2, 1'b0);
        wr("cw_coll", CSR_TCFG, 32'h0D, 1'b0, 32'h0, 1'b0);
        rd("cw_tval3", CSR_TVAL, 1'b1, 32'd3, 1'b1);
        do_reset(1'b1);
        rd("mr_tval", CSR_TVAL, 1'b1, 32'd0, 1'b0);
        rd("mr_tcfg", CSR_TCFG, 1'b1, 32'd0, 1'b0);
        rd("mr_tid", CSR_TID, 1'b1, TB_TID_RESET, 1'b0);
`endif

        idle(timer_int === 1'b1);
        idle(timer_int === 1'b1);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
